// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with a 16x oversampling tick generator and a
//            2-flop input synchroniser. Define UART_RX_PARITY_EN for 8E1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter logic [10:0] DIV_2400  = 11'd1302,
  parameter logic [10:0] DIV_4800  = 11'd651,
  parameter logic [10:0] DIV_9600  = 11'd326,
  parameter logic [10:0] DIV_12800 = 11'd244
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic [10:0] r_div;
  logic [10:0] w_div_sel;
  logic [10:0] r_tick_cnt;
  logic        w_tick;
  logic [3:0]  r_s_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        w_mid;
  logic        w_sample;
  logic        w_deliver;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_comb begin
    w_div_sel = DIV_12800;
    case (baud_rate)
      2'b00:   w_div_sel = DIV_2400;
      2'b01:   w_div_sel = DIV_4800;
      2'b10:   w_div_sel = DIV_9600;
      default: w_div_sel = DIV_12800;
    endcase
  end

  assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == r_div - 11'd1);
  assign w_mid     = w_tick && (r_s_cnt == 4'd7);
  assign w_sample  = w_tick && (r_s_cnt == 4'd15);
  assign w_deliver = (r_state == S_STOP) && w_sample;
  assign rx_busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (w_mid) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_sample && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sample) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_sample) w_state_nxt = r_rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div      <= 11'd0;
      r_tick_cnt <= 11'd0;
      r_s_cnt    <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
    end else begin
      if ((r_state == S_IDLE) && (w_state_nxt == S_START)) r_div <= w_div_sel;

      if ((r_state == S_IDLE) || w_tick) r_tick_cnt <= 11'd0;
      else r_tick_cnt <= r_tick_cnt + 11'd1;

      if (w_state_nxt != r_state) r_s_cnt <= 4'd0;
      else if (w_tick) r_s_cnt <= r_s_cnt + 4'd1;

      if (r_state == S_START) r_bit_idx <= 3'd0;
      else if ((r_state == S_DATA) && w_sample) r_bit_idx <= r_bit_idx + 3'd1;

      // Right shift so the first (LSB) bit on the line ends up in bit 0.
      if ((r_state == S_DATA) && w_sample) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= w_deliver;
      if (w_deliver) begin
        rx_data   <= r_shift;
        frame_err <= ~r_rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_sample) r_par <= r_rx_s;
      if (w_deliver) parity_err <= (^r_shift) ^ r_par;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
